pipe_step_ctl: RTL and testbench
================================

# pipe_step_ctl

Parametrised pipeline-advance and debug-trace controller for the 5-stage 16-bit core. It generalises the core's fixed divide-by-64 clock, pause/step logic and per-stage instruction readout. It adds configurable divider width and stage count, burst stepping of N advances, a PC breakpoint with halt and resume, an advance counter, and a register-scan address generator. It sits between the board inputs (switch and debounced button) and the core's pipeline registers, regfile scan port and display outputs.

## Interface
- DIV_W, 6: divider width; free-run advance period is 2^DIV_W cycles
- STAGES, 5: trace depth (pipeline stage count)
- INSN_W, 16: instruction width
- PC_W, 8: program counter width
- RA_W, 4: regfile address width for scan
- BURST_W, 8: burst count width
- CLK  in  1  system clock (100 MHz)
- RST_N  in  1  synchronous, active-low reset
- PAUSE  in  1  level; 1 = stepping mode
- STEP  in  1  single-cycle pulse from the debouncer (btn_down)
- BURST_GO  in  1  single-cycle pulse; start burst
- BURST_CNT  in  BURST_W  number of advances for a burst
- RESUME  in  1  single-cycle pulse; leave HALT
- BRK_EN  in  1  breakpoint enable
- BRK_PC  in  PC_W  breakpoint address
- PC  in  PC_W  core's current fetch PC
- IF_INSN  in  INSN_W  instruction being fetched
- FLUSH  in  1  IF/ID flush request from branch control
- ADVANCE  out  1  one-cycle pipeline-register enable
- WRITE_WINDOW  out  1  ADVANCE delayed one cycle (regfile write slot)
- SCAN_VALID  out  1  regfile port free for scan this cycle
- SCAN_RA  out  RA_W  scan read address
- TRACE  out  STAGES*INSN_W  stage i in bits [i*INSN_W +: INSN_W]; i=0 is IF
- STATE  out  2  00 PAUSED, 01 RUN, 10 BURST, 11 HALT
- ADV_COUNT  out  16  total advances, wrapping

## Operation
- Divider: DIV_W-bit counter; increments in RUN and BURST, held at 0 in PAUSED and HALT. tick = counter all ones.
- Event priority per cycle: reset > breakpoint > PAUSE/RESUME/BURST_GO > STEP.
- RUN: tick with BRK_EN=1, PC==BRK_PC and skip flag clear → no advance, go to HALT. Any other tick → advance. PAUSE=1 → PAUSED.
- PAUSED: PAUSE=0 → RUN. BURST_GO with BURST_CNT≠0 → BURST, remaining count loaded with BURST_CNT. BURST_GO with BURST_CNT=0 is ignored. STEP → advance, state unchanged.
- BURST: same tick and breakpoint rule as RUN. Each advance decrements remaining; the advance that takes it to 0 → PAUSED. PAUSE=0 → RUN, remaining discarded.
- HALT: STEP → advance, go to PAUSED. RESUME → RUN with skip flag set. Skip flag suppresses the breakpoint match for the next tick only, then clears. PAUSE is ignored in HALT.
- STEP in RUN or BURST is ignored. BURST_GO outside PAUSED is ignored.
- Trace: on advance, entry0 ← FLUSH ? 0 : IF_INSN, and entry i ← entry i-1. Otherwise hold.
- ADV_COUNT increments on each ADVANCE, wraps 0xFFFF→0.
- Scan: SCAN_VALID = ~ADVANCE & ~WRITE_WINDOW. SCAN_RA increments on each valid cycle and wraps 2^RA_W-1 → 0.

## Timing
- Reset (RST_N=0 at a CLK edge): STATE=PAUSED, divider=0, ADVANCE=0, WRITE_WINDOW=0, TRACE=0, ADV_COUNT=0, SCAN_RA=0, remaining=0, skip=0. SCAN_VALID=1 in the cycle after reset.
- Reset mid-burst or in HALT aborts immediately, with no advance issued.
- First cycle after reset with PAUSE=0: STATE→RUN.
- ADVANCE rises one cycle after its qualifying tick or STEP, and stays high for exactly one cycle.
- WRITE_WINDOW rises the cycle after ADVANCE.
- TRACE and ADV_COUNT update on the edge where ADVANCE=1, and are visible the following cycle.
- RUN: ADVANCE period exactly 2^DIV_W cycles.
- A breakpoint decision uses the PC at the tick cycle.
- Back-to-back STEP pulses on consecutive cycles give two ADVANCE pulses.

## Test plan
- Reset, PAUSE=0, DIV_W=6 -> STATE=01 after 1 cycle; first ADVANCE at cycle 65; then every 64 cycles; ADV_COUNT=4 after 4 pulses.
- PAUSE=1, three STEP pulses, IF_INSN=0x1234/0x2345/0x3456 -> 3 ADVANCE pulses; TRACE stage0..2 = 0x3456, 0x2345, 0x1234.
- PAUSED, BURST_CNT=3, BURST_GO -> exactly 3 ADVANCE pulses 64 cycles apart, then STATE=00. Repeat with BURST_CNT=0 -> no change.
- BRK_EN=1, BRK_PC=0x05, PC=0x05 at tick -> no ADVANCE, STATE=11. RESUME -> next tick advances with PC still 0x05, then STATE=01.
- FLUSH=1 during a STEP with IF_INSN=0xBEEF -> TRACE stage0=0x0000.
- Free-running scan -> SCAN_RA cycles 0..15 then wraps to 0; SCAN_VALID=0 exactly on ADVANCE and WRITE_WINDOW cycles.
- RST_N=0 mid-burst -> all outputs at reset values next cycle; no ADVANCE issued.

Source files
------------

// File: rtl/pipe_step_ctl.sv
// =============================================================================
// Module   : pipe_step_ctl
// Purpose  : Pipeline-advance / debug-trace controller (run, step, burst,
//            PC breakpoint, advance counter, regfile scan address generator).
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module pipe_step_ctl #(
  parameter int DIV_W   = 6,
  parameter int STAGES  = 5,
  parameter int INSN_W  = 16,
  parameter int PC_W    = 8,
  parameter int RA_W    = 4,
  parameter int BURST_W = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     pause_i,
  input  logic                     step_i,
  input  logic                     burst_go_i,
  input  logic [BURST_W-1:0]       burst_cnt_i,
  input  logic                     resume_i,
  input  logic                     brk_en_i,
  input  logic [PC_W-1:0]          brk_pc_i,
  input  logic [PC_W-1:0]          pc_i,
  input  logic [INSN_W-1:0]        if_insn_i,
  input  logic                     flush_i,
  output logic                     adv_o,
  output logic                     write_window_o,
  output logic                     scan_valid_o,
  output logic [RA_W-1:0]          scan_ra_o,
  output logic [STAGES*INSN_W-1:0] trace_o,
  output logic [1:0]               state_o,
  output logic [15:0]              adv_count_o
);

  typedef enum logic [1:0] {
    ST_PAUSED = 2'b00,
    ST_RUN    = 2'b01,
    ST_BURST  = 2'b10,
    ST_HALT   = 2'b11
  } state_e;

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BURST_W-1:0]   remain_q, remain_d;
  logic                 skip_q, skip_d;
  logic                 adv_q, adv_d;
  logic                 ww_q;
  logic [15:0]          cnt_q;
  logic [RA_W-1:0]      ra_q;
  logic [INSN_W-1:0]    trace_q [STAGES];
  logic                 tick;
  logic                 brk_hit;
  logic                 scan_valid;

  assign tick       = &div_q;
  assign brk_hit    = brk_en_i && (pc_i == brk_pc_i) && !skip_q;
  assign scan_valid = ~adv_q & ~ww_q;

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    skip_d   = skip_q;
    adv_d    = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (tick && brk_hit) begin
          state_d = ST_HALT;
        end else begin
          if (tick) begin
            adv_d  = 1'b1;
            skip_d = 1'b0;
          end
          if (pause_i) state_d = ST_PAUSED;
        end
      end
      ST_BURST: begin
        if (tick && brk_hit) begin
          state_d  = ST_HALT;
          remain_d = '0;
        end else begin
          if (tick) begin
            adv_d    = 1'b1;
            skip_d   = 1'b0;
            remain_d = remain_q - 1'b1;
            if (remain_q == BURST_W'(1)) state_d = ST_PAUSED;
          end
          if (!pause_i) begin
            state_d  = ST_RUN;
            remain_d = '0;
          end
        end
      end
      ST_PAUSED: begin
        if (!pause_i) begin
          state_d = ST_RUN;
        end else if (burst_go_i && (burst_cnt_i != '0)) begin
          state_d  = ST_BURST;
          remain_d = burst_cnt_i;
        end else if (step_i) begin
          adv_d = 1'b1;
        end
      end
      default: begin
        if (resume_i) begin
          state_d = ST_RUN;
          skip_d  = 1'b1;
        end else if (step_i) begin
          adv_d   = 1'b1;
          state_d = ST_PAUSED;
        end
      end
    endcase
  end

  // Divider restarts from zero whenever the controller enters or leaves a free-running state.
  always_comb begin
    div_d = '0;
    if ((state_q == ST_RUN || state_q == ST_BURST) &&
        (state_d == ST_RUN || state_d == ST_BURST))
      div_d = div_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_PAUSED;
      div_q    <= '0;
      remain_q <= '0;
      skip_q   <= 1'b0;
      adv_q    <= 1'b0;
      ww_q     <= 1'b0;
      cnt_q    <= '0;
      ra_q     <= '0;
      for (int i = 0; i < STAGES; i++) trace_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      remain_q <= remain_d;
      skip_q   <= skip_d;
      adv_q    <= adv_d;
      ww_q     <= adv_q;
      if (scan_valid) ra_q <= ra_q + 1'b1;
      if (adv_q) begin
        cnt_q      <= cnt_q + 16'd1;
        trace_q[0] <= flush_i ? '0 : if_insn_i;
        for (int i = 1; i < STAGES; i++) trace_q[i] <= trace_q[i-1];
      end
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_trace_pack
    assign trace_o[g*INSN_W +: INSN_W] = trace_q[g];
  end

  assign adv_o          = adv_q;
  assign write_window_o = ww_q;
  assign scan_valid_o   = scan_valid;
  assign scan_ra_o      = ra_q;
  assign state_o        = state_q;
  assign adv_count_o    = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_step_ctl.sv
// =============================================================================
// Module   : tb_pipe_step_ctl
// Purpose  : Directed self-checking bench for pipe_step_ctl.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_pipe_step_ctl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pause = 1'b0;
  logic        step = 1'b0;
  logic        burst_go = 1'b0;
  logic [7:0]  burst_cnt = 8'd0;
  logic        resume = 1'b0;
  logic        brk_en = 1'b0;
  logic [7:0]  brk_pc = 8'd0;
  logic [7:0]  pc = 8'd0;
  logic [15:0] if_insn = 16'd0;
  logic        flush = 1'b0;
  logic        adv, ww, scan_valid;
  logic [3:0]  scan_ra;
  logic [79:0] trace;
  logic [1:0]  state;
  logic [15:0] adv_count;

  int vectors = 0;
  int miscompares = 0;

  pipe_step_ctl dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .pause_i        (pause),
    .step_i         (step),
    .burst_go_i     (burst_go),
    .burst_cnt_i    (burst_cnt),
    .resume_i       (resume),
    .brk_en_i       (brk_en),
    .brk_pc_i       (brk_pc),
    .pc_i           (pc),
    .if_insn_i      (if_insn),
    .flush_i        (flush),
    .adv_o          (adv),
    .write_window_o (ww),
    .scan_valid_o   (scan_valid),
    .scan_ra_o      (scan_ra),
    .trace_o        (trace),
    .state_o        (state),
    .adv_count_o    (adv_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 80'(state), 80'h0);
    chk({tag, "_adv"},   80'(adv), 80'h0);
    chk({tag, "_ww"},    80'(ww), 80'h0);
    chk({tag, "_valid"}, 80'(scan_valid), 80'h1);
    chk({tag, "_ra"},    80'(scan_ra), 80'h0);
    chk({tag, "_trace"}, trace, 80'h0);
    chk({tag, "_count"}, 80'(adv_count), 80'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick_clk();
    tick_clk();
    rst_n = 1'b1;
  endtask

  initial begin
    bit exp_adv, exp_ww, exp_v;
    int ra;

    // Free-run: advance at cycle 65 then every 64; scan address sequence.
    pause = 1'b0;
    do_reset();
    ra = 0;
    for (int c = 0; c <= 258; c++) begin
      if (c > 0) tick_clk();
      if (c == 0) chk_reset_vals("reset1");
      exp_adv = (c >= 65) && (((c - 65) % 64) == 0);
      exp_ww  = (c >= 66) && (((c - 66) % 64) == 0);
      exp_v   = !(exp_adv || exp_ww);
      chk("run_adv",   80'(adv), 80'(exp_adv));
      chk("run_ww",    80'(ww), 80'(exp_ww));
      chk("run_valid", 80'(scan_valid), 80'(exp_v));
      chk("run_ra",    80'(scan_ra), 80'(ra));
      if (c >= 1) chk("run_state", 80'(state), 80'h1);
      if (exp_v) ra = (ra + 1) % 16;
    end
    chk("run_count", 80'(adv_count), 80'd4);

    // Stepping with back-to-back STEP pulses fills the trace.
    pause = 1'b1;
    do_reset();
    chk_reset_vals("reset2");
    step = 1'b1;
    tick_clk();
    chk("step1_adv", 80'(adv), 80'h1);
    if_insn = 16'h1234;
    tick_clk();
    chk("step2_adv", 80'(adv), 80'h1);
    if_insn = 16'h2345;
    tick_clk();
    chk("step3_adv", 80'(adv), 80'h1);
    step = 1'b0;
    if_insn = 16'h3456;
    tick_clk();
    chk("step_done_adv", 80'(adv), 80'h0);
    chk("step_ww",       80'(ww), 80'h1);
    chk("trace_s0",      80'(trace[15:0]), 80'h3456);
    chk("trace_s1",      80'(trace[31:16]), 80'h2345);
    chk("trace_s2",      80'(trace[47:32]), 80'h1234);
    chk("step_state",    80'(state), 80'h0);
    chk("step_count",    80'(adv_count), 80'd3);

    // Flushed step inserts a bubble into stage 0.
    step = 1'b1;
    tick_clk();
    step = 1'b0;
    flush = 1'b1;
    if_insn = 16'hBEEF;
    chk("flush_adv", 80'(adv), 80'h1);
    tick_clk();
    flush = 1'b0;
    chk("flush_s0",    80'(trace[15:0]), 80'h0000);
    chk("flush_s1",    80'(trace[31:16]), 80'h3456);
    chk("flush_s2",    80'(trace[47:32]), 80'h2345);
    chk("flush_count", 80'(adv_count), 80'd4);

    // Burst of three: advances 64 cycles apart, then back to PAUSED.
    burst_cnt = 8'd3;
    burst_go = 1'b1;
    tick_clk();
    burst_go = 1'b0;
    chk("burst_state", 80'(state), 80'h2);
    for (int k = 1; k <= 193; k++) begin
      tick_clk();
      chk("burst_adv", 80'(adv), 80'((k == 64) || (k == 128) || (k == 192)));
      if (k == 100) chk("burst_mid_state", 80'(state), 80'h2);
    end
    chk("burst_end_state", 80'(state), 80'h0);
    chk("burst_count",     80'(adv_count), 80'd7);

    // Zero-length burst is ignored.
    burst_cnt = 8'd0;
    burst_go = 1'b1;
    tick_clk();
    burst_go = 1'b0;
    chk("burst0_state", 80'(state), 80'h0);
    repeat (70) tick_clk();
    chk("burst0_state2", 80'(state), 80'h0);
    chk("burst0_count",  80'(adv_count), 80'd7);

    // Breakpoint: halt at tick, resume skips once, next match halts again.
    brk_en = 1'b1;
    brk_pc = 8'h05;
    pc = 8'h05;
    pause = 1'b0;
    tick_clk();
    chk("brk_run_state", 80'(state), 80'h1);
    for (int k = 1; k <= 64; k++) begin
      tick_clk();
      chk("brk_no_adv", 80'(adv), 80'h0);
    end
    chk("brk_halt_state", 80'(state), 80'h3);
    repeat (10) tick_clk();
    chk("halt_ignores_pause", 80'(state), 80'h3);
    chk("halt_count", 80'(adv_count), 80'd7);
    resume = 1'b1;
    tick_clk();
    resume = 1'b0;
    chk("resume_state", 80'(state), 80'h1);
    for (int k = 1; k <= 128; k++) begin
      tick_clk();
      chk("resume_adv", 80'(adv), 80'(k == 64));
      if (k == 64) chk("resume_run_state", 80'(state), 80'h1);
      if (k == 65) chk("resume_count", 80'(adv_count), 80'd8);
    end
    chk("rehalt_state", 80'(state), 80'h3);

    // STEP out of HALT advances and parks in PAUSED.
    pause = 1'b1;
    step = 1'b1;
    tick_clk();
    step = 1'b0;
    chk("halt_step_adv",   80'(adv), 80'h1);
    chk("halt_step_state", 80'(state), 80'h0);
    tick_clk();
    chk("halt_step_count", 80'(adv_count), 80'd9);
    brk_en = 1'b0;

    // Reset on the burst's first tick edge: no advance issued.
    burst_cnt = 8'd5;
    burst_go = 1'b1;
    tick_clk();
    burst_go = 1'b0;
    chk("burst2_state", 80'(state), 80'h2);
    for (int k = 1; k <= 63; k++) tick_clk();
    rst_n = 1'b0;
    tick_clk();
    rst_n = 1'b1;
    chk_reset_vals("midburst_reset");
    for (int k = 1; k <= 70; k++) begin
      tick_clk();
      chk("post_reset_adv", 80'(adv), 80'h0);
    end
    chk("post_reset_state", 80'(state), 80'h0);
    chk("post_reset_count", 80'(adv_count), 80'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
